// File: rtl/gfp8_group_packer.sv
// gfp8_group_packer: collects 32 FP16 elements one per cycle, finds the shared
// exponent (bias 15), converts LANES elements per cycle into signed 8-bit
// mantissas and presents one 256-bit GFP8 group under valid/ready.
//
// Ports
//   i_clk, i_reset_n     clock, synchronous active-low reset
//   i_valid/o_ready      element handshake; i_data is FP16, i_last ends a short group
//   o_valid/i_ready      group handshake
//   o_exp                shared exponent, 0 means an all-zero group
//   o_man                element k in o_man[8k+7:8k], two's complement
//
// Build option: GFP8_PACK_ROUND_EN selects round-half-away-from-zero with
// saturation at 127; without it mantissas are truncated toward zero.
module gfp8_group_packer #(
    parameter int          GROUP_ID = 0,
    parameter int unsigned LANES    = 4
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [15:0]  i_data,
    input  logic         i_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [4:0]   o_exp,
    output logic [255:0] o_man
);

    localparam int unsigned NSLOT = 32;
    localparam int unsigned NCYC  = NSLOT / LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16 || LANES == 32)) begin : g_bad_lanes
        $error("gfp8_group_packer %0d: illegal LANES %0d", GROUP_ID, LANES);
    end

    typedef enum logic [1:0] {COLLECT, CONVERT, OUTPUT} state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [4:0]  emax;
    logic [4:0]  cyc;
    logic [15:0] buffer [NSLOT];

    logic        accept_c;
    logic [15:0] eff_c;
    logic [4:0]  slot_c [LANES];
    logic [7:0]  lane_c [LANES];

    // One FP16 element (already in effective form) to a signed 8-bit mantissa.
    function automatic logic [7:0] to_man(input logic [15:0] el, input logic [4:0] emax_v);
        logic [10:0] sig;
        logic [5:0]  sh;
        logic [7:0]  mag;
`ifdef GFP8_PACK_ROUND_EN
        logic        rnd;
        logic [8:0]  sum;
`endif
        sig = {1'b1, el[9:0]};
        sh  = 6'd4 + 6'(emax_v - el[14:10]);
        mag = (sh >= 6'd11) ? 8'd0 : 8'(sig >> sh);
`ifdef GFP8_PACK_ROUND_EN
        rnd = ((sh - 6'd1) < 6'd11) ? sig[4'(sh - 6'd1)] : 1'b0;
        sum = 9'(mag) + 9'(rnd);
        mag = (sum > 9'd127) ? 8'd127 : sum[7:0];
`endif
        if (el[14:10] == 5'd0) begin
            return 8'd0;
        end
        return el[15] ? 8'(~mag + 8'd1) : mag;
    endfunction

    // Zero/subnormal flush to an all-zero slot; Inf/NaN become the largest finite.
    always_comb begin
        eff_c = i_data;
        if (i_data[14:10] == 5'd0) begin
            eff_c = '0;
        end else if (i_data[14:10] == 5'd31) begin
            eff_c = {i_data[15], 5'd30, 10'h3FF};
        end
    end

    assign accept_c = (state == COLLECT) && o_ready && i_valid;

    // Slots handled in the current CONVERT cycle and their mantissas.
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            slot_c[l] = 5'(32'(cyc) * LANES + 32'(l));
            lane_c[l] = to_man(buffer[slot_c[l]], emax);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= COLLECT;
            idx     <= '0;
            emax    <= '0;
            cyc     <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_exp   <= '0;
            o_man   <= '0;
            for (int i = 0; i < int'(NSLOT); i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept_c) begin
                        buffer[idx] <= eff_c;
                        idx         <= idx + 5'd1;
                        if (eff_c[14:10] > emax) begin
                            emax <= eff_c[14:10];
                        end
                        if (idx == 5'd31 || i_last) begin
                            state   <= CONVERT;
                            o_ready <= 1'b0;
                            cyc     <= '0;
                        end
                    end
                end
                CONVERT: begin
                    if (cyc == 5'd0) begin
                        o_exp <= emax;
                    end
                    for (int l = 0; l < int'(LANES); l++) begin
                        o_man[{slot_c[l], 3'b000} +: 8] <= lane_c[l];
                    end
                    if (cyc == 5'(NCYC - 1)) begin
                        state <= OUTPUT;
                    end else begin
                        cyc <= cyc + 5'd1;
                    end
                end
                OUTPUT: begin
                    // o_valid rises one edge after conversion ends; held until taken.
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        idx     <= '0;
                        emax    <= '0;
                        state   <= COLLECT;
                        for (int i = 0; i < int'(NSLOT); i++) begin
                            buffer[i] <= '0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_gfp8_group_packer.sv
// Scoreboard bench for gfp8_group_packer with LANES=4: the stimulus queues the
// expected group, a negedge monitor compares each group at its handshake.
module tb_gfp8_group_packer;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic         i_valid;
    logic         o_ready;
    logic [15:0]  i_data;
    logic         i_last;
    logic         o_valid;
    logic         i_ready;
    logic [4:0]   o_exp;
    logic [255:0] o_man;

    typedef struct packed {
        logic [4:0]   e;
        logic [255:0] m;
    } grp_t;

    grp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef GFP8_PACK_ROUND_EN
    localparam logic [7:0] B3C18 = 8'h42;
`else
    localparam logic [7:0] B3C18 = 8'h41;
`endif

    always #5 clk = ~clk;

    gfp8_group_packer #(.GROUP_ID(0), .LANES(4)) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_exp     (o_exp),
        .o_man     (o_man)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each group when the handshake happens.
    always @(negedge clk) begin
        if (i_reset_n === 1'b1 && o_valid === 1'b1) begin
            check("valid_ready_excl", 256'(o_ready), 256'(0));
            if (i_ready === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_group", 256'(1), 256'(0));
                end else begin
                    grp_t g;
                    g = q.pop_front();
                    check("group_exp", 256'(o_exp), 256'(g.e));
                    check("group_man", o_man, g.m);
                end
            end
        end
    end

    task automatic push_elem(input logic [15:0] d, input logic l);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 16'hDEAD;
    endtask

    task automatic run_group(input string name, input logic [15:0] d [32], input int n,
                             input logic last_on_final, input logic [4:0] e,
                             input logic [255:0] m, input int stall);
        int   cnt;
        grp_t g;
        g.e = e;
        g.m = m;
        q.push_back(g);
        i_ready = (stall == 0);
        for (int i = 0; i < n; i++) begin
            push_elem(d[i], last_on_final && (i == n - 1));
        end
        check({name, "_ready_low"}, 256'(o_ready), 256'(0));
        cnt = 0;
        while (o_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({name, "_latency"}, 256'(cnt), 256'(9));
        for (int k = 0; k < stall; k++) begin
            check({name, "_stall_valid"}, 256'(o_valid), 256'(1));
            check({name, "_stall_exp"}, 256'(o_exp), 256'(e));
            check({name, "_stall_man"}, o_man, m);
            check({name, "_stall_ready"}, 256'(o_ready), 256'(0));
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, 256'(o_valid), 256'(0));
        check({name, "_ready_rise"}, 256'(o_ready), 256'(1));
    endtask

    initial begin
        logic [15:0] d [32];
        logic [255:0] all40, all7f, all42, allc0;
        for (int i = 0; i < 32; i++) begin
            all40[8*i +: 8] = 8'h40;
            all7f[8*i +: 8] = 8'h7F;
            all42[8*i +: 8] = B3C18;
            allc0[8*i +: 8] = 8'hC0;
        end

        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_last    = 1'b0;
        i_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        check("rst_valid", 256'(o_valid), 256'(0));
        check("rst_ready", 256'(o_ready), 256'(1));
        check("rst_exp", 256'(o_exp), 256'(0));
        check("rst_man", o_man, 256'(0));

        for (int i = 0; i < 32; i++) d[i] = 16'h3C00;
        run_group("ones", d, 32, 1'b0, 5'd15, all40, 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h0000;
        d[0] = 16'h4000;
        d[1] = 16'hBC00;
        run_group("mixed", d, 32, 1'b0, 5'd16, 256'hE040, 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h3C00;
        run_group("short", d, 3, 1'b1, 5'd15, 256'h404040, 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h0001;
        run_group("subnorm", d, 32, 1'b0, 5'd0, 256'(0), 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h7C00;
        run_group("inf", d, 32, 1'b0, 5'd30, all7f, 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h3C18;
        run_group("round", d, 32, 1'b0, 5'd15, all42, 0);

        // i_last on slot 31 must behave like a plain full group.
        for (int i = 0; i < 32; i++) d[i] = 16'h3FFF;
        run_group("sat", d, 32, 1'b1, 5'd15, all7f, 0);

        for (int i = 0; i < 32; i++) d[i] = 16'h3C00;
        run_group("stall", d, 32, 1'b0, 5'd15, all40, 5);

        // Abort a partial group with a one-cycle reset, then a fresh group.
        for (int i = 0; i < 10; i++) push_elem(16'h4000, 1'b0);
        i_reset_n = 1'b0;
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        check("abort_valid", 256'(o_valid), 256'(0));
        check("abort_exp", 256'(o_exp), 256'(0));
        check("abort_man", o_man, 256'(0));
        check("abort_ready", 256'(o_ready), 256'(1));
        for (int i = 0; i < 32; i++) d[i] = 16'hC000;
        run_group("fresh", d, 32, 1'b0, 5'd16, allc0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 256'(q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
